// File: rtl/lighting_pkg.sv
// Shared definitions for the flat-shading lighting stage.
// Contents:
//   - fixed-point width constants for every datapath stage
//   - vector struct typedefs at coordinate, edge and cross-product width
//   - FSM state enum
//   - fp16_to_fixed: IEEE half -> signed Q(COORD_INT).(FRAC_BITS), truncating toward zero
//   - scale8: 8-bit colour channel times Q0.8 intensity (256 = 1.0)
package lighting_pkg;

    localparam int FRAC_BITS = 10;
    localparam int COORD_INT = 8;

    // sign + integer + fraction
    localparam int COORD_W = COORD_INT + FRAC_BITS + 1;
    // difference of two saturated coordinates needs one extra bit
    localparam int EDGE_W  = COORD_W + 1;
    // |e|<2^(EDGE_W-1) so each product is <2^(2*EDGE_W-2); a difference of two fits in 2*EDGE_W signed
    localparam int CROSS_W = 2 * EDGE_W;
    // n.L: product <2^(CROSS_W+COORD_W-2), sum of three needs two more bits plus sign
    localparam int DOT_W   = CROSS_W + COORD_W + 2;
    // |n|^2: three squares each <2^(2*CROSS_W-2) stay below 2^(2*CROSS_W)
    localparam int M2_W    = 2 * CROSS_W;
    localparam int ROOT_W  = M2_W / 2;

    localparam logic [COORD_W-1:0] COORD_MAX = {1'b0, {(COORD_W-1){1'b1}}};

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
        logic signed [COORD_W-1:0] z;
    } vec3_t;

    typedef struct packed {
        logic signed [EDGE_W-1:0] x;
        logic signed [EDGE_W-1:0] y;
        logic signed [EDGE_W-1:0] z;
    } edge_vec_t;

    typedef struct packed {
        logic signed [CROSS_W-1:0] x;
        logic signed [CROSS_W-1:0] y;
        logic signed [CROSS_W-1:0] z;
    } cross_vec_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_EDGE  = 3'd2,
        ST_CROSS = 3'd3,
        ST_DOT   = 3'd4,
        ST_SQRT  = 3'd5,
        ST_DIV   = 3'd6,
        ST_SHADE = 3'd7
    } state_t;

    // Half-precision to signed fixed point. Magnitude is {1,mantissa} shifted by
    // (exp - 25 + FRAC_BITS); right shifts drop bits, i.e. truncate toward zero.
    function automatic logic signed [COORD_W-1:0] fp16_to_fixed(input logic [15:0] h);
        logic [4:0]         ex;
        logic [9:0]         man;
        logic [COORD_W-1:0] mag;
        int                 sh;
        ex  = h[14:10];
        man = h[9:0];
        sh  = int'(ex) - 32'sd25 + FRAC_BITS;
        if (ex == 5'd0) begin
            mag = '0;
        end else if (ex == 5'd31) begin
            mag = (man == 10'd0) ? COORD_MAX : '0;
        end else if (int'(ex) - 32'sd15 >= COORD_INT) begin
            mag = COORD_MAX;
        end else if (sh >= 32'sd0) begin
            mag = COORD_W'({1'b1, man}) << sh;
        end else begin
            mag = COORD_W'({1'b1, man}) >> (-sh);
        end
        if (h[15]) begin
            return -$signed(mag);
        end else begin
            return $signed(mag);
        end
    endfunction

    // (c * i) >> 8 with i in [0,256]; i = 256 returns c unchanged.
    function automatic logic [7:0] scale8(input logic [7:0] c, input logic [8:0] i);
        return 8'((16'(c) * 16'(i)) >> 8);
    endfunction

endpackage

// File: rtl/lighting_isqrt.sv
// Restoring bit-serial integer square root: root = floor(sqrt(radicand)).
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   start         load radicand and begin (one pulse)
//   radicand      W-bit unsigned operand
//   root          W/2-bit result, held after done
//   done          one-cycle pulse exactly W/2 cycles after start
module lighting_isqrt
    import lighting_pkg::*;
#(
    parameter int W = M2_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     radicand,
    output logic [W/2-1:0]   root,
    output logic             done
);

    localparam int RW    = W / 2;
    localparam int REM_W = RW + 2;
    localparam int CNT_W = $clog2(RW);

    logic [W-1:0]       rad_r;
    logic [REM_W-1:0]   rem_r;
    logic [RW-1:0]      root_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               done_r;

    logic [REM_W+1:0]   rem_sh_s;
    logic [REM_W+1:0]   trial_s;
    logic [REM_W+1:0]   diff_s;
    logic               ge_s;

    // One iteration: bring down two radicand bits, try subtracting (4*root+1).
    always_comb begin
        rem_sh_s = {rem_r, rad_r[W-1 -: 2]};
        trial_s  = {2'b00, root_r, 2'b01};
        diff_s   = rem_sh_s - trial_s;
        ge_s     = (rem_sh_s >= trial_s);
    end

    // Iteration state, count and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rad_r  <= '0;
            rem_r  <= '0;
            root_r <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                rad_r  <= radicand;
                rem_r  <= '0;
                root_r <= '0;
                cnt_r  <= '0;
                busy_r <= 1'b1;
            end else if (busy_r) begin
                rad_r <= rad_r << 2;
                if (ge_s) begin
                    rem_r  <= REM_W'(diff_s);
                    root_r <= {root_r[RW-2:0], 1'b1};
                end else begin
                    rem_r  <= REM_W'(rem_sh_s);
                    root_r <= {root_r[RW-2:0], 1'b0};
                end
                if (cnt_r == CNT_W'(RW - 1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 1'b1;
                end
            end
        end
    end

    assign root = root_r;
    assign done = done_r;

endmodule

// File: rtl/lighting.sv
// Flat-shading stage: one triangle per request. Computes the face normal,
// tests it against the light direction and scales the base colour by the
// Lambert intensity. Latency from accepted en to valid is fixed (54 cycles).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   en             start; sampled only while idle
//   triangle       {v0,v1,v2}, each {x,y,z} fp16
//   light_vec      {x,y,z} fp16 direction the light travels
//   input_rgb      {R,G,B} base colour
//   output_rgb     shaded colour
//   valid          one-cycle pulse when output_rgb/illuminated update
//   illuminated    front face receives light
module lighting
    import lighting_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [143:0] triangle,
    input  logic [47:0]  light_vec,
    input  logic [23:0]  input_rgb,
    output logic [23:0]  output_rgb,
    output logic         valid,
    output logic         illuminated
);

    state_t                  state_r, state_s;

    logic [143:0]            tri_in_r;
    logic [47:0]             light_in_r;
    logic [23:0]             rgb_in_r;
    vec3_t                   v0_r, v1_r, v2_r, l_r;
    edge_vec_t               e1_r, e2_r;
    cross_vec_t              n_r;
    logic signed [DOT_W-1:0] d_r;
    logic                    lit_r;
    logic [DOT_W-1:0]        div_rem_r;
    logic [DOT_W-1:0]        div_den_r;
    logic [7:0]              div_q_r;
    logic [2:0]              div_cnt_r;
    logic                    clamp_r;
    logic [23:0]             rgb_out_r;
    logic                    valid_r;
    logic                    ill_r;

    vec3_t                   v0_s, v1_s, v2_s, l_s;
    edge_vec_t               e1_s, e2_s;
    cross_vec_t              n_s;
    logic signed [DOT_W-1:0] d_s;
    logic [M2_W-1:0]         m2_s;
    logic                    lit_s;
    logic [DOT_W-1:0]        neg_d_s;
    logic [DOT_W-1:0]        den_s;
    logic [DOT_W:0]          rem2_s;
    logic [DOT_W:0]          div_sub_s;
    logic                    div_ge_s;
    logic [8:0]              intensity_s;
    logic                    sqrt_start_s;
    logic [ROOT_W-1:0]       sqrt_root_s;
    logic                    sqrt_done_s;

    lighting_isqrt #(.W(M2_W)) u_isqrt (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sqrt_start_s),
        .radicand (m2_s),
        .root     (sqrt_root_s),
        .done     (sqrt_done_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and square-root launch. SQRT and DIV always run their full
    // length so latency does not depend on whether the face is lit.
    always_comb begin
        state_s      = state_r;
        sqrt_start_s = 1'b0;
        case (state_r)
            ST_IDLE:  state_s = en ? ST_CONV : ST_IDLE;
            ST_CONV:  state_s = ST_EDGE;
            ST_EDGE:  state_s = ST_CROSS;
            ST_CROSS: state_s = ST_DOT;
            ST_DOT: begin
                state_s      = ST_SQRT;
                sqrt_start_s = 1'b1;
            end
            ST_SQRT:  state_s = sqrt_done_s ? ST_DIV : ST_SQRT;
            ST_DIV:   state_s = (div_cnt_r == 3'd7) ? ST_SHADE : ST_DIV;
            ST_SHADE: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Per-stage arithmetic feeding the datapath registers.
    always_comb begin
        v0_s.x = fp16_to_fixed(tri_in_r[143:128]);
        v0_s.y = fp16_to_fixed(tri_in_r[127:112]);
        v0_s.z = fp16_to_fixed(tri_in_r[111:96]);
        v1_s.x = fp16_to_fixed(tri_in_r[95:80]);
        v1_s.y = fp16_to_fixed(tri_in_r[79:64]);
        v1_s.z = fp16_to_fixed(tri_in_r[63:48]);
        v2_s.x = fp16_to_fixed(tri_in_r[47:32]);
        v2_s.y = fp16_to_fixed(tri_in_r[31:16]);
        v2_s.z = fp16_to_fixed(tri_in_r[15:0]);
        l_s.x  = fp16_to_fixed(light_in_r[47:32]);
        l_s.y  = fp16_to_fixed(light_in_r[31:16]);
        l_s.z  = fp16_to_fixed(light_in_r[15:0]);

        e1_s.x = EDGE_W'(v1_r.x) - EDGE_W'(v0_r.x);
        e1_s.y = EDGE_W'(v1_r.y) - EDGE_W'(v0_r.y);
        e1_s.z = EDGE_W'(v1_r.z) - EDGE_W'(v0_r.z);
        e2_s.x = EDGE_W'(v2_r.x) - EDGE_W'(v0_r.x);
        e2_s.y = EDGE_W'(v2_r.y) - EDGE_W'(v0_r.y);
        e2_s.z = EDGE_W'(v2_r.z) - EDGE_W'(v0_r.z);

        n_s.x = CROSS_W'(e1_r.y) * CROSS_W'(e2_r.z) - CROSS_W'(e1_r.z) * CROSS_W'(e2_r.y);
        n_s.y = CROSS_W'(e1_r.z) * CROSS_W'(e2_r.x) - CROSS_W'(e1_r.x) * CROSS_W'(e2_r.z);
        n_s.z = CROSS_W'(e1_r.x) * CROSS_W'(e2_r.y) - CROSS_W'(e1_r.y) * CROSS_W'(e2_r.x);

        d_s  = DOT_W'(n_r.x) * DOT_W'(l_r.x) + DOT_W'(n_r.y) * DOT_W'(l_r.y)
             + DOT_W'(n_r.z) * DOT_W'(l_r.z);
        m2_s = $unsigned(M2_W'(n_r.x) * M2_W'(n_r.x) + M2_W'(n_r.y) * M2_W'(n_r.y)
             + M2_W'(n_r.z) * M2_W'(n_r.z));
        lit_s = d_s[DOT_W-1] && (m2_s != '0);

        // d is scaled by 2^(3*FRAC_BITS), |n| by 2^(2*FRAC_BITS): align the divisor.
        neg_d_s   = $unsigned(-d_r);
        den_s     = DOT_W'({sqrt_root_s, {FRAC_BITS{1'b0}}});
        rem2_s    = {div_rem_r, 1'b0};
        div_sub_s = rem2_s - {1'b0, div_den_r};
        div_ge_s  = (rem2_s >= {1'b0, div_den_r});
        intensity_s = clamp_r ? 9'd256 : {1'b0, div_q_r};
    end

    // Datapath registers, loaded in the state that produces them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tri_in_r   <= '0;
            light_in_r <= '0;
            rgb_in_r   <= '0;
            v0_r       <= '0;
            v1_r       <= '0;
            v2_r       <= '0;
            l_r        <= '0;
            e1_r       <= '0;
            e2_r       <= '0;
            n_r        <= '0;
            d_r        <= '0;
            lit_r      <= 1'b0;
            div_rem_r  <= '0;
            div_den_r  <= '0;
            div_q_r    <= '0;
            div_cnt_r  <= '0;
            clamp_r    <= 1'b0;
            rgb_out_r  <= '0;
            valid_r    <= 1'b0;
            ill_r      <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        tri_in_r   <= triangle;
                        light_in_r <= light_vec;
                        rgb_in_r   <= input_rgb;
                    end
                end
                ST_CONV: begin
                    v0_r <= v0_s;
                    v1_r <= v1_s;
                    v2_r <= v2_s;
                    l_r  <= l_s;
                end
                ST_EDGE: begin
                    e1_r <= e1_s;
                    e2_r <= e2_s;
                end
                ST_CROSS: n_r <= n_s;
                ST_DOT: begin
                    d_r   <= d_s;
                    lit_r <= lit_s;
                end
                ST_SQRT: begin
                    // -d >= |n| already means intensity 1.0; the quotient is then ignored.
                    if (sqrt_done_s) begin
                        div_rem_r <= neg_d_s;
                        div_den_r <= den_s;
                        clamp_r   <= (neg_d_s >= den_s);
                        div_q_r   <= '0;
                        div_cnt_r <= '0;
                    end
                end
                ST_DIV: begin
                    if (div_ge_s) begin
                        div_rem_r <= DOT_W'(div_sub_s);
                        div_q_r   <= {div_q_r[6:0], 1'b1};
                    end else begin
                        div_rem_r <= DOT_W'(rem2_s);
                        div_q_r   <= {div_q_r[6:0], 1'b0};
                    end
                    div_cnt_r <= div_cnt_r + 3'd1;
                end
                ST_SHADE: begin
                    valid_r <= 1'b1;
                    if (lit_r) begin
                        rgb_out_r <= {scale8(rgb_in_r[23:16], intensity_s),
                                      scale8(rgb_in_r[15:8],  intensity_s),
                                      scale8(rgb_in_r[7:0],   intensity_s)};
                        ill_r     <= 1'b1;
                    end else begin
                        rgb_out_r <= '0;
                        ill_r     <= 1'b0;
                    end
                end
                default: valid_r <= 1'b0;
            endcase
        end
    end

    assign output_rgb  = rgb_out_r;
    assign valid       = valid_r;
    assign illuminated = ill_r;

endmodule

// File: tb/tb_lighting.sv
// Directed self-checking bench for the lighting stage.
module tb_lighting;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [143:0] triangle;
    logic [47:0]  light_vec;
    logic [23:0]  input_rgb;
    logic [23:0]  output_rgb;
    logic         valid;
    logic         illuminated;

    int passed  = 0;
    int fails   = 0;
    int total   = 0;
    int lat_ref = -1;

    // fp16: 1=3c00, 2=4000, -1=bc00, -2=c000
    localparam logic [143:0] TRI_LIT   = 144'h4000_3c00_0000_0000_3c00_0000_3c00_0000_0000;
    localparam logic [143:0] TRI_UNLIT = 144'h4000_3c00_0000_3c00_0000_0000_0000_3c00_0000;
    localparam logic [143:0] TRI_N312  = 144'h4000_3c00_c000_0000_3c00_3c00_3c00_0000_0000;
    localparam logic [143:0] TRI_DEGEN = 144'h3c00_3c00_3c00_3c00_3c00_3c00_3c00_3c00_3c00;
    localparam logic [47:0]  L_DOWN    = 48'h0000_0000_bc00;

    lighting dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .triangle    (triangle),
        .light_vec   (light_vec),
        .input_rgb   (input_rgb),
        .output_rgb  (output_rgb),
        .valid       (valid),
        .illuminated (illuminated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit near_ok(input logic [23:0] a, input logic [23:0] b, input int tol);
        bit ok;
        ok = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            int da;
            da = int'(a[ch*8 +: 8]) - int'(b[ch*8 +: 8]);
            if (da < -tol || da > tol) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check_rgb(input string tag, input logic [23:0] obs, input logic [23:0] exp,
                             input int tol);
        total++;
        assert (near_ok(obs, exp, tol) === 1'b1) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %06h expected %06h tol %0d", tag, obs, exp, tol);
        end
    endtask

    // One request; inputs are scrambled right after acceptance.
    task automatic run_case(input string tag, input logic [143:0] t, input logic [47:0] l,
                            input logic [23:0] c, input logic exp_ill,
                            input logic [23:0] exp_rgb, input int tol);
        int lat;
        triangle  = t;
        light_vec = l;
        input_rgb = c;
        en        = 1'b1;
        @(negedge clk);
        en        = 1'b0;
        triangle  = ~t;
        light_vec = ~l;
        input_rgb = ~c;
        lat = 1;
        while (valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_valid_seen"}, 32'(valid), 32'd1);
        check({tag, "_lat_le_64"}, 32'(lat <= 64), 32'd1);
        if (lat_ref < 0) lat_ref = lat;
        else check({tag, "_latency"}, 32'(lat), 32'(lat_ref));
        check({tag, "_illum"}, 32'(illuminated), 32'(exp_ill));
        check_rgb({tag, "_rgb"}, output_rgb, exp_rgb, tol);
        @(negedge clk);
        check({tag, "_valid_single"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int nv;
        int first;
        rst_n     = 1'b0;
        en        = 1'b0;
        triangle  = '0;
        light_vec = '0;
        input_rgb = '0;
        repeat (3) @(negedge clk);
        check("reset_rgb",   32'(output_rgb),  32'd0);
        check("reset_illum", 32'(illuminated), 32'd0);
        check("reset_valid", 32'(valid),       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_case("lit_white",    TRI_LIT,   L_DOWN, 24'hffffff, 1'b1, 24'hffffff, 0);
        run_case("unlit_white",  TRI_UNLIT, L_DOWN, 24'hffffff, 1'b0, 24'h000000, 0);
        run_case("n312_white",   TRI_N312,  L_DOWN, 24'hffffff, 1'b1, 24'h878787, 1);
        run_case("n312_d088d0",  TRI_N312,  L_DOWN, 24'hd088d0, 1'b1, 24'h6e486e, 1);
        run_case("unlit_d088d0", TRI_UNLIT, L_DOWN, 24'hd088d0, 1'b0, 24'h000000, 0);
        run_case("degenerate",   TRI_DEGEN, L_DOWN, 24'hffffff, 1'b0, 24'h000000, 0);
        run_case("lit_d088d0",   TRI_LIT,   L_DOWN, 24'hd088d0, 1'b1, 24'hd088d0, 0);

        // en held high while busy, plus a stray pulse late in the computation
        triangle  = TRI_LIT;
        light_vec = L_DOWN;
        input_rgb = 24'hffffff;
        en        = 1'b1;
        nv        = 0;
        first     = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 40) en = 1'b0;
            if (k == 48) en = 1'b1;
            if (k == 49) en = 1'b0;
            if (valid === 1'b1) begin
                nv++;
                if (first < 0) first = k;
            end
        end
        check("held_en_valid_count", 32'(nv),    32'd1);
        check("held_en_latency",     32'(first), 32'(lat_ref));
        check("held_en_rgb",         32'(output_rgb), 32'hffffff);

        // reset in the middle of a request
        triangle  = TRI_LIT;
        input_rgb = 24'hd088d0;
        en        = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_rgb",   32'(output_rgb),  32'd0);
        check("midrst_illum", 32'(illuminated), 32'd0);
        check("midrst_valid", 32'(valid),       32'd0);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (valid === 1'b1) nv++;
        end
        check("midrst_no_valid", 32'(nv), 32'd0);
        check("midrst_rgb_hold", 32'(output_rgb), 32'd0);

        run_case("after_rst_lit", TRI_LIT, L_DOWN, 24'hffffff, 1'b1, 24'hffffff, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
